// File: rtl/router_pkt_pkg.sv
// router_pkt_pkg: header field layout, FSM state encoding and width helpers
// shared by the router send and receive controllers.
package router_pkt_pkg;

    // Header word field positions (inclusive bit ranges).
    localparam int SRC_LSB = 0;
    localparam int SRC_MSB = 1;
    localparam int PN_LSB  = 2;
    localparam int PN_MSB  = 6;
    localparam int TTL_LSB = 7;
    localparam int TTL_MSB = 8;
    localparam int DST_LSB = 9;
    localparam int DST_MSB = 18;

    // Receive controller FSM state encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Width of the packet-number field for a given packet-number modulus.
    function automatic int pn_w(input int number_packet);
        return $clog2(number_packet);
    endfunction

endpackage

// File: rtl/router_rx_hdr_decode.sv
// router_rx_hdr_decode: splits a 64-bit packet header word into its fields
// and flags an expired (TTL==0) packet. Purely combinational.
module router_rx_hdr_decode
    import router_pkt_pkg::*;
#(
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH             = 10,
    parameter int PN_W                   = 5,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2
) (
    input  logic [AURORA_DATA_WIDTH-1:0]      hdr,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] src,
    output logic [PN_W-1:0]                   pn,
    output logic                              ttl_zero,
    output logic [ADDR_WIDTH-1:0]             dst
);

    // Reserved header bits carry no meaning on the receive side.
    logic unused_reserved;

    assign src             = hdr[SRC_MSB:SRC_LSB];
    assign pn              = hdr[PN_MSB:PN_LSB];
    assign ttl_zero        = (hdr[TTL_MSB:TTL_LSB] == '0);
    assign dst             = hdr[DST_MSB:DST_LSB];
    assign unused_reserved = ^hdr[AURORA_DATA_WIDTH-1:DST_MSB+1];

endmodule

// File: rtl/router_rx_controller.sv
// router_rx_controller: drains packets from output port 0, decodes the
// header, obtains a memory write slot from the arbiter and streams the
// payload to the destination address range. Expired packets are drained.
module router_rx_controller
    import router_pkt_pkg::*;
#(
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH             = 10,
    parameter int NUMBER_PACKET          = 19,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int PAYLOAD_WORDS          = 16,
    parameter int PN_W                   = pn_w(NUMBER_PACKET)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx_enable,
    input  logic                              empty_output_port_0,
    input  logic [AURORA_DATA_WIDTH-1:0]      data_output_port_0,
    output logic                              rd_output_port_0,
    output logic                              arbiter_write_req,
    input  logic                              arbiter_write_gnt,
    output logic [ADDR_WIDTH-1:0]             arbiter_dst_addr,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [AURORA_DATA_WIDTH-1:0]      mem_wdata,
    output logic                              rx_busy,
    output logic                              rx_pkt_done,
    output logic                              rx_drop,
    output logic                              rx_seq_err,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] rx_src_router,
    output logic [PN_W-1:0]                   rx_pkt_number
);

    localparam int               CNT_W   = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PAYLOAD_WORDS);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(PAYLOAD_WORDS - 1);

    logic [2:0]                        state;
    logic [2:0]                        state_nxt;
    logic                              rd;
    logic                              rd_q;      // a pop was issued last cycle
    logic                              wr_fire;
    logic [CNT_W-1:0]                  issued;
    logic [CNT_W-1:0]                  written;
    logic [ADDR_WIDTH-1:0]             dst_q;
    logic [PN_W-1:0]                   pn_exp;
    logic [PN_W-1:0]                   pn_next;

    logic [RECOGNIZE_ROUTER_WIDTH-1:0] hdr_src;
    logic [PN_W-1:0]                   hdr_pn;
    logic                              hdr_ttl_zero;
    logic [ADDR_WIDTH-1:0]             hdr_dst;

    router_rx_hdr_decode #(
        .AURORA_DATA_WIDTH      (AURORA_DATA_WIDTH),
        .ADDR_WIDTH             (ADDR_WIDTH),
        .PN_W                   (PN_W),
        .RECOGNIZE_ROUTER_WIDTH (RECOGNIZE_ROUTER_WIDTH)
    ) u_hdr_decode (
        .hdr      (data_output_port_0),
        .src      (hdr_src),
        .pn       (hdr_pn),
        .ttl_zero (hdr_ttl_zero),
        .dst      (hdr_dst)
    );

    // Next expected packet number after the one just received, mod NUMBER_PACKET.
    assign pn_next = PN_W'((32'(hdr_pn) + 32'd1) % 32'(NUMBER_PACKET));

    // Payload words become valid one cycle after their pop; write them then.
    assign wr_fire = rd_q && (state == ST_STREAM);

    // Next-state and FIFO pop decisions.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt = state;
        rd        = 1'b0;
        case (state)
            ST_IDLE: begin
                // Reset is folded in so the FIFO is never popped while held in reset.
                if (rx_enable && !empty_output_port_0 && !rst) begin
                    rd        = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                state_nxt = hdr_ttl_zero ? ST_DRAIN : ST_REQ;
            end
            ST_REQ: begin
                if (arbiter_write_gnt) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                rd = !empty_output_port_0 && arbiter_write_gnt && (issued != LAST);
                if (wr_fire && (written == LAST_M1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                rd = !empty_output_port_0 && (issued != LAST);
                if (issued == LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and the one-cycle pop history that marks valid FIFO data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rd_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
            rd_q  <= rd;
        end
    end

    // Per-packet issue/write counters, cleared while the header is decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued  <= '0;
            written <= '0;
        end else if (state == ST_HDR) begin
            issued  <= '0;
            written <= '0;
        end else begin
            if (rd) begin
                issued <= issued + 1'b1;
            end
            if (wr_fire) begin
                written <= written + 1'b1;
            end
        end
    end

    // Header capture, status fields and packet-number sequence tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q         <= '0;
            pn_exp        <= '0;
            rx_seq_err    <= 1'b0;
            rx_src_router <= '0;
            rx_pkt_number <= '0;
        end else if (state == ST_HDR) begin
            dst_q         <= hdr_dst;
            rx_src_router <= hdr_src;
            rx_pkt_number <= hdr_pn;
            // On a match or a mismatch the tracker resyncs to the received number.
            pn_exp        <= pn_next;
            if (hdr_pn != pn_exp) begin
                rx_seq_err <= 1'b1;
            end
        end
    end

    assign rd_output_port_0  = rd;
    assign arbiter_write_req = (state == ST_REQ) || (state == ST_STREAM);
    assign arbiter_dst_addr  = arbiter_write_req ? dst_q : '0;
    assign mem_we            = wr_fire;
    assign mem_addr          = wr_fire ? (dst_q + ADDR_WIDTH'(written)) : '0;
    assign mem_wdata         = wr_fire ? data_output_port_0 : '0;
    assign rx_busy           = (state != ST_IDLE);
    assign rx_pkt_done       = (state == ST_DONE);
    assign rx_drop           = (state == ST_DRAIN) && (issued == LAST);

endmodule

// File: tb/tb_router_rx_controller.sv
// tb_router_rx_controller: directed bench for the receive controller with a
// behavioural output-port FIFO and an event monitor sampling on the falling edge.
module tb_router_rx_controller;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_enable;
    logic        empty_output_port_0;
    logic [63:0] data_output_port_0 = '0;
    logic        rd_output_port_0;
    logic        arbiter_write_req;
    logic        arbiter_write_gnt;
    logic [9:0]  arbiter_dst_addr;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        rx_busy;
    logic        rx_pkt_done;
    logic        rx_drop;
    logic        rx_seq_err;
    logic [1:0]  rx_src_router;
    logic [4:0]  rx_pkt_number;

    router_rx_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_enable           (rx_enable),
        .empty_output_port_0 (empty_output_port_0),
        .data_output_port_0  (data_output_port_0),
        .rd_output_port_0    (rd_output_port_0),
        .arbiter_write_req   (arbiter_write_req),
        .arbiter_write_gnt   (arbiter_write_gnt),
        .arbiter_dst_addr    (arbiter_dst_addr),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .rx_busy             (rx_busy),
        .rx_pkt_done         (rx_pkt_done),
        .rx_drop             (rx_drop),
        .rx_seq_err          (rx_seq_err),
        .rx_src_router       (rx_src_router),
        .rx_pkt_number       (rx_pkt_number)
    );

    always #5 clk = ~clk;

    // Output-port FIFO model: read data appears one cycle after the pop.
    logic [63:0] fifo_mem [0:2047];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign empty_output_port_0 = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rd_output_port_0 && (rd_ptr != wr_ptr)) begin
            data_output_port_0 <= fifo_mem[11'(rd_ptr)];
            rd_ptr             <= rd_ptr + 1;
        end
    end

    // Event monitor: cumulative counts and per-event cycle stamps.
    int          cyc = 0;
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, drop_cnt = 0;
    int          req_cnt = 0, gq_cnt = 0, rd_empty_cnt = 0, done_cyc = 0;
    logic [9:0]  wr_addr [0:1023];
    logic [63:0] wr_data [0:1023];
    int          we_cyc  [0:1023];
    int          rd_cyc  [0:1023];
    int          gq_cyc  [0:1023];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[10'(wr_cnt)] = mem_addr;
            wr_data[10'(wr_cnt)] = mem_wdata;
            we_cyc[10'(wr_cnt)]  = cyc;
            wr_cnt++;
        end
        if (rd_output_port_0) begin
            rd_cyc[10'(rd_cnt)] = cyc;
            rd_cnt++;
            if (empty_output_port_0) rd_empty_cnt++;
        end
        if (arbiter_write_req) req_cnt++;
        if (arbiter_write_req && arbiter_write_gnt) begin
            gq_cyc[10'(gq_cnt)] = cyc;
            gq_cnt++;
        end
        if (rx_pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rx_drop) drop_cnt++;
        cyc++;
    end

    int n_cmp = 0;
    int n_mis = 0;
    int b_wr, b_rd, b_done, b_drop, b_req, b_gq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_wr   = wr_cnt;
        b_rd   = rd_cnt;
        b_done = done_cnt;
        b_drop = drop_cnt;
        b_req  = req_cnt;
        b_gq   = gq_cnt;
    endtask

    function automatic logic [63:0] hdr(input int src, input int pn, input int ttl, input int dst);
        return {45'h0A5A5, 10'(dst), 2'(ttl), 5'(pn), 2'(src)};
    endfunction

    function automatic logic [63:0] pay(input int pkt, input int j);
        return {16'hD00D, 16'(pkt), 32'(j)};
    endfunction

    task automatic push(input logic [63:0] w);
        fifo_mem[11'(wr_ptr)] = w;
        wr_ptr++;
    endtask

    task automatic push_pay(input int pkt, input int from, input int to);
        for (int j = from; j < to; j++) push(pay(pkt, j));
    endtask

    // Waits for the next done or drop pulse; an expired budget shows up as a miss.
    task automatic wait_end(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt + drop_cnt;
        n = 0;
        while ((done_cnt + drop_cnt) == start && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_ended"}, 64'(done_cnt + drop_cnt - start), 64'd1);
        tick(1);
    endtask

    // Checks the P writes of one packet against base address and payload tag.
    task automatic check_writes(input string tag, input int pkt, input int dst);
        check({tag, "_wr_count"}, 64'(wr_cnt - b_wr), 64'(P));
        for (int i = 0; i < P; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[10'(b_wr + i)]), 64'((dst + i) % 1024));
            check($sformatf("%s_data%0d", tag, i), wr_data[10'(b_wr + i)], pay(pkt, i));
        end
    endtask

    initial begin
        int n;
        int wr_at_rst;

        rst               = 1'b1;
        rx_enable         = 1'b0;
        arbiter_write_gnt = 1'b0;
        #1;
        check("rst_ctrl", 64'({rd_output_port_0, arbiter_write_req, mem_we, rx_busy,
                               rx_pkt_done, rx_drop, rx_seq_err}), 64'd0);
        check("rst_fields", 64'({arbiter_dst_addr, mem_addr, rx_src_router, rx_pkt_number}), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("idle_busy", 64'(rx_busy), 64'd0);

        // Normal packet: TTL=2, pn=0, dst=0x100, grant already high.
        snap();
        push(hdr(1, 0, 2, 'h100));
        push_pay(1, 0, P);
        arbiter_write_gnt = 1'b1;
        rx_enable         = 1'b1;
        wait_end("norm", 100);
        check_writes("norm", 1, 'h100);
        check("norm_done", 64'(done_cnt - b_done), 64'd1);
        check("norm_seq_err", 64'(rx_seq_err), 64'd0);
        check("norm_src", 64'(rx_src_router), 64'd1);
        check("norm_pn", 64'(rx_pkt_number), 64'd0);
        // Header pop -> REQ with grant seen: 2; grant -> first write: 2.
        check("norm_pop_to_req", 64'(gq_cyc[10'(b_gq)] - rd_cyc[10'(b_rd)]), 64'd2);
        check("norm_gnt_to_we", 64'(we_cyc[10'(b_wr)] - gq_cyc[10'(b_gq)]), 64'd2);
        check("norm_back_to_back", 64'(we_cyc[10'(b_wr + P - 1)] - we_cyc[10'(b_wr)]), 64'(P - 1));
        check("norm_done_after_we", 64'(done_cyc - we_cyc[10'(b_wr + P - 1)]), 64'd1);
        // Header pop edge to done edge: P+4 edges, i.e. P+5 cycles inclusive.
        check("norm_latency", 64'(done_cyc - rd_cyc[10'(b_rd)]), 64'(P + 4));
        check("norm_busy", 64'(rx_busy), 64'd0);

        // Grant delayed 5 cycles in REQ: pn=1, dst=0x040.
        snap();
        arbiter_write_gnt = 1'b0;
        push(hdr(3, 1, 1, 'h040));
        push_pay(2, 0, P);
        n = 0;
        while (!arbiter_write_req && n < 20) begin
            tick(1);
            n++;
        end
        check("gd_req_seen", 64'(arbiter_write_req), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("gd_req_hold%0d", i), 64'(arbiter_write_req), 64'd1);
            tick(1);
        end
        check("gd_dst_addr", 64'(arbiter_dst_addr), 64'h040);
        check("gd_no_write", 64'(wr_cnt - b_wr), 64'd0);
        arbiter_write_gnt = 1'b1;
        wait_end("gd", 100);
        check_writes("gd", 2, 'h040);
        check("gd_gnt_to_we", 64'(we_cyc[10'(b_wr)] - gq_cyc[10'(b_gq)]), 64'd2);
        check("gd_src", 64'(rx_src_router), 64'd3);

        // Underflow: only words 0..7 available, then 3 empty cycles.
        snap();
        push(hdr(1, 2, 3, 'h200));
        push_pay(3, 0, 8);
        n = 0;
        while ((wr_cnt - b_wr) < 8 && n < 60) begin
            tick(1);
            n++;
        end
        check("uf_first_half", 64'(wr_cnt - b_wr), 64'd8);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("uf_no_rd%0d", i), 64'(rd_output_port_0), 64'd0);
            tick(1);
        end
        check("uf_stalled_pops", 64'(rd_cnt - b_rd), 64'd9);
        check("uf_stalled_writes", 64'(wr_cnt - b_wr), 64'd8);
        push_pay(3, 8, P);
        wait_end("uf", 100);
        check_writes("uf", 3, 'h200);
        check("uf_rd_when_empty", 64'(rd_empty_cnt), 64'd0);

        // TTL=0: drained, no request, no writes, one drop pulse.
        snap();
        push(hdr(0, 3, 0, 'h155));
        push_pay(4, 0, P);
        wait_end("ttl0", 100);
        check("ttl0_pops", 64'(rd_cnt - b_rd), 64'(P + 1));
        check("ttl0_writes", 64'(wr_cnt - b_wr), 64'd0);
        check("ttl0_req", 64'(req_cnt - b_req), 64'd0);
        check("ttl0_drop", 64'(drop_cnt - b_drop), 64'd1);
        check("ttl0_done", 64'(done_cnt - b_done), 64'd0);
        check("ttl0_pn", 64'(rx_pkt_number), 64'd3);
        check("ttl0_seq_err", 64'(rx_seq_err), 64'd0);

        // Address wrap: dst=0x3FA runs through 0x3FF into 0x000..0x009.
        snap();
        push(hdr(2, 4, 1, 'h3FA));
        push_pay(5, 0, P);
        wait_end("wrap", 100);
        check_writes("wrap", 5, 'h3FA);

        // Reset mid-stream after word 5: everything returns to zero, no pulse.
        snap();
        push(hdr(2, 5, 3, 'h080));
        push_pay(6, 0, P);
        n = 0;
        while ((wr_cnt - b_wr) < 5 && n < 60) begin
            tick(1);
            n++;
        end
        check("mr_reached_word5", 64'(wr_cnt - b_wr), 64'd5);
        rst = 1'b1;
        #1;
        check("mr_ctrl", 64'({rd_output_port_0, arbiter_write_req, mem_we, rx_busy,
                              rx_pkt_done, rx_drop, rx_seq_err}), 64'd0);
        check("mr_fields", 64'({arbiter_dst_addr, mem_addr, rx_src_router, rx_pkt_number}), 64'd0);
        check("mr_wdata", mem_wdata, 64'd0);
        wr_at_rst = wr_cnt;
        wr_ptr    = rd_ptr;
        tick(2);
        rst = 1'b0;
        tick(5);
        check("mr_no_done", 64'(done_cnt - b_done), 64'd0);
        check("mr_no_drop", 64'(drop_cnt - b_drop), 64'd0);
        check("mr_no_more_writes", 64'(wr_cnt - wr_at_rst), 64'd0);
        check("mr_idle", 64'(rx_busy), 64'd0);

        // Sequence: 0..18 then 0 wraps cleanly; then 1, then 3 flags an error.
        snap();
        for (int k = 0; k < 20; k++) begin
            push(hdr(1, k % 19, 0, 'h010));
            push_pay(100 + k, 0, P);
            wait_end($sformatf("seq%0d", k), 100);
        end
        check("seq_wrap_no_err", 64'(rx_seq_err), 64'd0);
        check("seq_wrap_drops", 64'(drop_cnt - b_drop), 64'd20);
        check("seq_wrap_pn", 64'(rx_pkt_number), 64'd0);
        push(hdr(1, 1, 0, 'h010));
        push_pay(120, 0, P);
        wait_end("seq_pn1", 100);
        check("seq_pn1_no_err", 64'(rx_seq_err), 64'd0);
        push(hdr(1, 3, 0, 'h010));
        push_pay(121, 0, P);
        wait_end("seq_pn3", 100);
        check("seq_pn3_err", 64'(rx_seq_err), 64'd1);
        check("seq_pn3_number", 64'(rx_pkt_number), 64'd3);
        push(hdr(1, 4, 0, 'h010));
        push_pay(122, 0, P);
        wait_end("seq_pn4", 100);
        check("seq_err_sticky", 64'(rx_seq_err), 64'd1);
        check("final_rd_when_empty", 64'(rd_empty_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
